// File: rtl/fft8_pkg.sv
// Shared constants, state encoding and index types for the 8-point FFT butterfly scheduler.
// Optional inverse transform support is enabled by defining FFT_INVERSE_EN.
package fft8_pkg;

  localparam int N             = 8;
  localparam int LOG2N         = 3;
  localparam int NSTAGES       = 3;
  localparam int OPS_PER_STAGE = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-1:0] twid_t;
  typedef logic [LOG2N-1:0] op_t;
  typedef logic [1:0]       stage_t;

  // Conjugate twiddle: W^-x == W^(N-x) for an N-point transform.
  function automatic twid_t conj_tw(input twid_t tw);
    return twid_t'(N - int'(tw));
  endfunction

endpackage

// File: rtl/fft8_bfly_scheduler_if.sv
// Control and buffer-address bus of the FFT butterfly scheduler.
// The inverse input exists only when FFT_INVERSE_EN is defined.
interface fft8_bfly_scheduler_if;
  import fft8_pkg::*;

`ifdef FFT_INVERSE_EN
  logic   inverse;
`endif
  logic   start;
  logic   busy;
  logic   done;
  logic   rd_en;
  addr_t  rd_addr_a;
  addr_t  rd_addr_b;
  twid_t  twiddle_index;
  logic   wr_en;
  addr_t  wr_addr;
  logic   bank_sel;
  stage_t stage;

  modport master (
`ifdef FFT_INVERSE_EN
    input  inverse,
`endif
    input  start,
    output busy, done, rd_en,
    output rd_addr_a, rd_addr_b,
    output twiddle_index,
    output wr_en, wr_addr,
    output bank_sel, stage
  );

  modport slave (
`ifdef FFT_INVERSE_EN
    output inverse,
`endif
    output start,
    input  busy, done, rd_en,
    input  rd_addr_a, rd_addr_b,
    input  twiddle_index,
    input  wr_en, wr_addr,
    input  bank_sel, stage
  );

endinterface

// File: rtl/fft8_addr_gen.sv
// Radix-2 DIT index arithmetic: maps (stage, butterfly, half) to
// operand addresses, twiddle index and write-back target.
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  stage_t     stage,
  input  logic [1:0] j,
  input  logic       h,
  input  logic       inverse,
  output addr_t      a,
  output addr_t      b,
  output twid_t      twiddle_index,
  output addr_t      wr_addr
);

  logic [2:0] jj;
  logic [2:0] span;
  logic [2:0] pos;
  logic [2:0] base;
  logic [2:0] k;
  twid_t      tw;

  // Butterfly geometry and twiddle selection for the current op.
  always_comb begin
    jj   = {1'b0, j};
    span = 3'd1 << stage;
    pos  = jj & (span - 3'd1);
    base = (jj >> stage) << (stage + 2'd1);
    a    = base + pos;
    b    = a + span;
    k    = pos << (2'd2 - stage);
    tw   = k + {h, 2'b00};
    twiddle_index = inverse ? conj_tw(tw) : tw;
    wr_addr       = h ? b : a;
  end

endmodule

// File: rtl/fft8_bfly_scheduler.sv
// Issues the 12 butterflies of an 8-point FFT as 24 ops on one multiply-add unit.
// Define FFT_INVERSE_EN to add the latched inverse (conjugate twiddle) mode.
module fft8_bfly_scheduler
  import fft8_pkg::*;
#(
  parameter int LAT    = 6,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft8_bfly_scheduler_if.master bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  stage_t          stage_q, stage_d;
  logic            bank_q, bank_d;
  logic            done_q, done_d;
  logic            inv_q;

  logic            issue;
  addr_t           ag_a, ag_b, ag_wr;
  twid_t           ag_tw;

  logic [LAT-1:0]    pipe_v;
  logic [ADDR_W-1:0] pipe_a [LAT];

`ifdef FFT_INVERSE_EN
  logic inv_d;
`endif

  fft8_addr_gen u_addr (
    .stage         (stage_q),
    .j             (op_q[2:1]),
    .h             (op_q[0]),
    .inverse       (inv_q),
    .a             (ag_a),
    .b             (ag_b),
    .twiddle_index (ag_tw),
    .wr_addr       (ag_wr)
  );

  // Next-state logic: op counter in ISSUE, LAT-cycle drain between stages.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
`ifdef FFT_INVERSE_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          op_d    = '0;
          stage_d = '0;
          bank_d  = 1'b0;
`ifdef FFT_INVERSE_EN
          inv_d   = bus.inverse;
`endif
        end
      end
      ISSUE: begin
        op_d = op_q + 3'd1;
        if (op_q == op_t'(OPS_PER_STAGE - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(LAT - 1)) begin
          bank_d = ~bank_q;
          op_d   = '0;
          if (stage_q == stage_t'(NSTAGES - 1)) begin
            state_d = IDLE;
            stage_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

`ifdef FFT_INVERSE_EN
  // Transform direction, held for the whole transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`else
  assign inv_q = 1'b0;
`endif

  assign issue = (state_q == ISSUE);

  // Write-back delay line matching the multiply-add latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LAT; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= issue;
      pipe_a[0] <= ADDR_W'(ag_wr);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.rd_en         = issue;
  assign bus.rd_addr_a     = issue ? ag_a  : '0;
  assign bus.rd_addr_b     = issue ? ag_b  : '0;
  assign bus.twiddle_index = issue ? ag_tw : '0;
  assign bus.wr_en         = pipe_v[LAT-1];
  assign bus.wr_addr       = pipe_v[LAT-1] ? addr_t'(pipe_a[LAT-1]) : '0;
  assign bus.bank_sel      = bank_q;
  assign bus.stage         = stage_q;

endmodule

// File: tb/tb_fft8_bfly_scheduler.sv
// Directed bench for fft8_bfly_scheduler with LAT=6.
// Inverse-mode steps are included when FFT_INVERSE_EN is defined.
module tb_fft8_bfly_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   now = 0;
  int   wr_cnt = 0;
  int   snap;
  int   t0;

  int ea1 [8] = '{0, 0, 1, 1, 4, 4, 5, 5};
  int eb1 [8] = '{2, 2, 3, 3, 6, 6, 7, 7};
  int et1 [8] = '{0, 4, 2, 6, 0, 4, 2, 6};
  int ea2 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int eb2 [8] = '{4, 4, 5, 5, 6, 6, 7, 7};
  int et2 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

  fft8_bfly_scheduler_if bus ();

  fft8_bfly_scheduler #(.LAT(6), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.wr_en === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int n);
    while (now < n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic chk_rd(input string tag, input int a, input int b,
                        input int tw);
    chk({tag, ".rd_en"}, 32'(bus.rd_en), 32'd1);
    chk({tag, ".a"}, 32'(bus.rd_addr_a), 32'(a));
    chk({tag, ".b"}, 32'(bus.rd_addr_b), 32'(b));
    chk({tag, ".tw"}, 32'(bus.twiddle_index), 32'(tw));
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef FFT_INVERSE_EN
    bus.inverse = 1'b0;
`endif
    adv_to(3);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.rd_en", 32'(bus.rd_en), 0);
    chk("rst.wr_en", 32'(bus.wr_en), 0);
    chk("rst.bank", 32'(bus.bank_sel), 0);
    chk("rst.stage", 32'(bus.stage), 0);
    chk("rst.addr", {bus.rd_addr_a, bus.rd_addr_b, bus.twiddle_index,
                     bus.wr_addr}, 0);
    rst_n = 1'b1;
    adv_to(6);
    chk("idle.rd_en", 32'(bus.rd_en), 0);
    chk("idle.busy", 32'(bus.busy), 0);

    t0 = 10;
    adv_to(t0);
    snap = wr_cnt;
    bus.start = 1'b1;
    adv_to(t0 + 1);
    bus.start = 1'b0;
    chk("s0.busy", 32'(bus.busy), 1);
    chk("s0.bank", 32'(bus.bank_sel), 0);
    chk("s0.stage", 32'(bus.stage), 0);
    chk_rd("s0.op0", 0, 1, 0);
    adv_to(t0 + 2);
    chk_rd("s0.op1", 0, 1, 4);
    adv_to(t0 + 3);
    chk_rd("s0.op2", 2, 3, 0);
    adv_to(t0 + 6);
    chk("s0.wr_early", 32'(bus.wr_en), 0);
    adv_to(t0 + 7);
    chk("s0.wr0_en", 32'(bus.wr_en), 1);
    chk("s0.wr0_addr", 32'(bus.wr_addr), 0);
    adv_to(t0 + 8);
    chk("s0.wr1_en", 32'(bus.wr_en), 1);
    chk("s0.wr1_addr", 32'(bus.wr_addr), 1);
    chk_rd("s0.op7", 6, 7, 4);
    adv_to(t0 + 9);
    chk("s0.drain_rd", 32'(bus.rd_en), 0);
    chk("s0.drain_busy", 32'(bus.busy), 1);
    adv_to(t0 + 14);
    chk("s0.wr7_en", 32'(bus.wr_en), 1);
    chk("s0.wr7_addr", 32'(bus.wr_addr), 7);
    chk("s0.last_stage", 32'(bus.stage), 0);

    for (int i = 0; i < 8; i++) begin
      adv_to(t0 + 15 + i);
      bus.start = (i == 5);
      chk_rd($sformatf("s1.op%0d", i), ea1[i], eb1[i], et1[i]);
      chk($sformatf("s1.bank%0d", i), 32'(bus.bank_sel), 1);
      chk($sformatf("s1.stage%0d", i), 32'(bus.stage), 1);
    end
    adv_to(t0 + 23);
    bus.start = 1'b0;
    chk("s1.drain_rd", 32'(bus.rd_en), 0);

    for (int i = 0; i < 8; i++) begin
      adv_to(t0 + 29 + i);
      chk_rd($sformatf("s2.op%0d", i), ea2[i], eb2[i], et2[i]);
      chk($sformatf("s2.bank%0d", i), 32'(bus.bank_sel), 0);
    end
    adv_to(t0 + 42);
    chk("end.busy", 32'(bus.busy), 1);
    chk("end.wr_en", 32'(bus.wr_en), 1);
    chk("end.wr_addr", 32'(bus.wr_addr), 7);
    chk("end.done_early", 32'(bus.done), 0);
    adv_to(t0 + 43);
    chk("done.pulse", 32'(bus.done), 1);
    chk("done.busy", 32'(bus.busy), 0);
    chk("done.bank", 32'(bus.bank_sel), 1);
    chk("done.rd_en", 32'(bus.rd_en), 0);
    chk("done.wr_count", 32'(wr_cnt - snap), 24);
    bus.start = 1'b1;

    t0 = t0 + 43;
    adv_to(t0 + 1);
    bus.start = 1'b0;
    chk("re.done_clear", 32'(bus.done), 0);
    chk("re.bank", 32'(bus.bank_sel), 0);
    chk("re.busy", 32'(bus.busy), 1);
    chk_rd("re.op0", 0, 1, 0);

    adv_to(t0 + 18);
    chk("rs.pre_rd", 32'(bus.rd_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs.busy", 32'(bus.busy), 0);
    chk("rs.rd_en", 32'(bus.rd_en), 0);
    chk("rs.wr_en", 32'(bus.wr_en), 0);
    chk("rs.bank", 32'(bus.bank_sel), 0);
    adv_to(t0 + 20);
    rst_n = 1'b1;
    snap = wr_cnt;
    adv_to(t0 + 34);
    chk("rs.no_wr", 32'(wr_cnt - snap), 0);
    chk("rs.idle", 32'(bus.busy), 0);

`ifdef FFT_INVERSE_EN
    t0 = t0 + 40;
    adv_to(t0);
    bus.start = 1'b1;
    bus.inverse = 1'b1;
    adv_to(t0 + 1);
    bus.start = 1'b0;
    bus.inverse = 1'b0;
    chk_rd("inv.s0.op0", 0, 1, 0);
    adv_to(t0 + 2);
    chk_rd("inv.s0.op1", 0, 1, 4);
    adv_to(t0 + 31);
    chk_rd("inv.s2.op2", 1, 5, 7);
    adv_to(t0 + 32);
    chk_rd("inv.s2.op3", 1, 5, 3);
    adv_to(t0 + 43);
    chk("inv.done", 32'(bus.done), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
